// File: rtl/spi_slave.sv
// SPI slave endpoint: SCLK, MOSI and SS_N are oversampled in the CLK domain; all four CPOL/CPHA modes, MSB first.
// Received bytes leave as a one-cycle strobe; transmit bytes enter through a one-deep valid/ready holding register.
module spi_slave #(
    parameter int         SYNC_STAGES   = 2,
    parameter int         IDLE_TIMEOUT  = 64,
    parameter logic [7:0] UNDERRUN_BYTE = 8'hFF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CPOL,
    input  logic       CPHA,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       SS_N,
    output logic       MISO,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_Valid,
    output logic       Tx_Ready,
    output logic [7:0] Rx_Data,
    output logic       Rx_Valid,
    output logic       Rx_Abort,
    output logic       Tx_Underrun,
    output logic       Busy
);

    localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic                   sclk_d;
    logic                   ss_d;

    logic                   sclk_s;
    logic                   mosi_s;
    logic                   ss_s;

    logic                   sclk_edge;
    logic                   lead_edge;
    logic                   trail_edge;
    logic                   sample_edge;
    logic                   shift_edge;
    logic                   ss_fall;
    logic                   wrap;
    logic                   byte_load;
    logic                   timeout_hit;
    logic                   abort_cond;
    logic                   tx_write;

    logic [2:0]             bit_cnt;
    logic [6:0]             rx_shift;
    logic [7:0]             tx_shift;
    logic [7:0]             hold_data;
    logic                   hold_full;
    logic [IDLE_W-1:0]      idle_cnt;

    // SCLK synchroniser idles at CPOL so reset never looks like a clock edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            mosi_sync <= '0;
            ss_sync   <= {SYNC_STAGES{1'b1}};
            sclk_d    <= CPOL;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_N};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];

    assign sclk_edge   = sclk_s ^ sclk_d;
    assign lead_edge   = sclk_edge & ~ss_s & (sclk_s ^ CPOL);
    assign trail_edge  = sclk_edge & ~ss_s & ~(sclk_s ^ CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign ss_fall     = ss_d & ~ss_s;

    assign wrap        = sample_edge && (bit_cnt == 3'd7);
    // CPHA=0 needs bit 7 on MISO before the first leading edge, hence the extra load at select.
    assign byte_load   = (shift_edge && (bit_cnt == 3'd0)) || (ss_fall && !CPHA);
    assign timeout_hit = (IDLE_TIMEOUT != 0) && (bit_cnt != 3'd0) && !sclk_edge && (idle_cnt == IDLE_LIMIT);
    assign abort_cond  = (bit_cnt != 3'd0) && (ss_s || timeout_hit) && !wrap;
    assign tx_write    = Tx_Valid && Tx_Ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idle_cnt <= '0;
        end else if (sclk_edge || (bit_cnt == 3'd0) || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
            Rx_Data  <= 8'd0;
            Rx_Valid <= 1'b0;
            Rx_Abort <= 1'b0;
        end else begin
            Rx_Valid <= wrap;
            Rx_Abort <= abort_cond;
            if (sample_edge) begin
                rx_shift <= {rx_shift[5:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (wrap) begin
                    Rx_Data <= {rx_shift, mosi_s};
                end
            end else if (abort_cond) begin
                bit_cnt <= 3'd0;
            end
        end
    end

    // A write landing on the same edge as a load refills the holding register after the old byte is taken.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_shift    <= 8'd0;
            hold_data   <= 8'd0;
            hold_full   <= 1'b0;
            Tx_Underrun <= 1'b0;
        end else begin
            Tx_Underrun <= byte_load && !hold_full;
            if (byte_load) begin
                tx_shift <= hold_full ? hold_data : UNDERRUN_BYTE;
            end else if (shift_edge) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (tx_write) begin
                hold_data <= Tx_Data;
                hold_full <= 1'b1;
            end else if (byte_load) begin
                hold_full <= 1'b0;
            end
        end
    end

    assign MISO     = ~ss_s & tx_shift[7];
    assign Tx_Ready = ~hold_full;
    assign Busy     = (bit_cnt != 3'd0);

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master drives all four modes; a strobe monitor and a byte-level
// model of the link predict received bytes, MISO bytes, underrun and abort counts.
module tb_spi_slave;

    localparam int         SYNC_STAGES   = 2;
    localparam int         IDLE_TIMEOUT  = 64;
    localparam logic [7:0] UNDERRUN_BYTE = 8'hFF;
    localparam int         H             = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CPOL, CPHA, SCLK, MOSI, SS_N;
    logic       MISO;
    logic [7:0] Tx_Data;
    logic       Tx_Valid;
    logic       Tx_Ready;
    logic [7:0] Rx_Data;
    logic       Rx_Valid, Rx_Abort, Tx_Underrun, Busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0] rx_q[$];
    int valid_cnt    = 0;
    int abort_cnt    = 0;
    int underrun_cnt = 0;

    typedef struct packed {
        logic       cpol;
        logic       cpha;
        logic       tx_valid;
        logic [7:0] tx_byte;
        logic [7:0] mosi_byte;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        logic [3:0] exp_und;
    } vec_t;

    spi_slave #(
        .SYNC_STAGES  (SYNC_STAGES),
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .UNDERRUN_BYTE(UNDERRUN_BYTE)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CPOL       (CPOL),
        .CPHA       (CPHA),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .SS_N       (SS_N),
        .MISO       (MISO),
        .Tx_Data    (Tx_Data),
        .Tx_Valid   (Tx_Valid),
        .Tx_Ready   (Tx_Ready),
        .Rx_Data    (Rx_Data),
        .Rx_Valid   (Rx_Valid),
        .Rx_Abort   (Rx_Abort),
        .Tx_Underrun(Tx_Underrun),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    // Strobe monitor, sampled on the inactive edge.
    always @(negedge CLK) begin
        if (!RST) begin
            if (Rx_Valid) begin
                rx_q.push_back(Rx_Data);
                valid_cnt++;
            end
            if (Rx_Abort) abort_cnt++;
            if (Tx_Underrun) underrun_cnt++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] rx_at(input int idx);
        if (idx < rx_q.size()) return rx_q[idx];
        return 8'hxx;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_mode(input logic cpol, input logic cpha);
        SS_N = 1'b1;
        CPOL = cpol;
        CPHA = cpha;
        SCLK = cpol;
        MOSI = 1'b0;
        wait_cycles(10);
    endtask

    task automatic ss_low();
        SS_N = 1'b0;
        wait_cycles(H);
    endtask

    task automatic frame_end();
        wait_cycles(H);
        SS_N = 1'b1;
        wait_cycles(12);
    endtask

    task automatic queue_tx(input logic [7:0] b);
        Tx_Data  = b;
        Tx_Valid = 1'b1;
        wait_cycles(1);
        Tx_Valid = 1'b0;
    endtask

    // Master side: MISO is captured at the master's own sample edge.
    task automatic spi_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!CPHA) begin
                MOSI = mo[i];
                wait_cycles(H);
                mi[i] = MISO;
                SCLK  = ~CPOL;
                wait_cycles(H);
                SCLK = CPOL;
            end else begin
                wait_cycles(H);
                SCLK = ~CPOL;
                MOSI = mo[i];
                wait_cycles(H);
                mi[i] = MISO;
                SCLK  = CPOL;
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int         base_q, base_v, base_u;
        logic [7:0] mi;
        base_q = rx_q.size();
        base_v = valid_cnt;
        base_u = underrun_cnt;
        set_mode(v.cpol, v.cpha);
        if (v.tx_valid) begin
            queue_tx(v.tx_byte);
            checkOutput($sformatf("vec%0d_ready_drop", idx), 32'(Tx_Ready), 32'd0);
        end
        ss_low();
        spi_byte(v.mosi_byte, 8, mi);
        frame_end();
        checkOutput($sformatf("vec%0d_valid_cnt", idx), 32'(valid_cnt - base_v), 32'd1);
        checkOutput($sformatf("vec%0d_rx", idx), 32'(rx_at(base_q)), 32'(v.exp_rx));
        checkOutput($sformatf("vec%0d_miso", idx), 32'(mi), 32'(v.exp_miso));
        checkOutput($sformatf("vec%0d_underrun", idx), 32'(underrun_cnt - base_u), 32'(v.exp_und));
        checkOutput($sformatf("vec%0d_ready", idx), 32'(Tx_Ready), 32'd1);
    endtask

    initial begin
        vec_t       vecs[5];
        logic [7:0] mi, mi2;
        int         base_q, base_v, base_u, base_a;

        // {cpol, cpha, tx_valid, tx, mosi, exp_rx, exp_miso, exp_underruns}; CPHA=0 reloads after the last bit.
        vecs[0] = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 4'd1};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81, 4'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81, 4'd1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81, 4'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 8'h5A, 8'hFF, 4'd1};

        RST = 1'b1; CPOL = 1'b0; CPHA = 1'b0; SCLK = 1'b0; MOSI = 1'b0; SS_N = 1'b1;
        Tx_Data = 8'h00; Tx_Valid = 1'b0;
        wait_cycles(3);
        checkOutput("rst_miso", 32'(MISO), 32'd0);
        checkOutput("rst_rx_data", 32'(Rx_Data), 32'd0);
        checkOutput("rst_rx_valid", 32'(Rx_Valid), 32'd0);
        checkOutput("rst_rx_abort", 32'(Rx_Abort), 32'd0);
        checkOutput("rst_underrun", 32'(Tx_Underrun), 32'd0);
        checkOutput("rst_busy", 32'(Busy), 32'd0);
        checkOutput("rst_tx_ready", 32'(Tx_Ready), 32'd1);
        RST = 1'b0;
        wait_cycles(3);

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

        $display("[TB] back-to-back bytes");
        base_q = rx_q.size(); base_v = valid_cnt;
        set_mode(1'b0, 1'b0);
        queue_tx(8'h11);
        ss_low();
        queue_tx(8'h22);
        spi_byte(8'hF0, 8, mi);
        spi_byte(8'h0F, 8, mi2);
        frame_end();
        checkOutput("b2b_valid_cnt", 32'(valid_cnt - base_v), 32'd2);
        checkOutput("b2b_rx0", 32'(rx_at(base_q)), 32'hF0);
        checkOutput("b2b_rx1", 32'(rx_at(base_q + 1)), 32'h0F);
        checkOutput("b2b_miso0", 32'(mi), 32'h11);
        checkOutput("b2b_miso1", 32'(mi2), 32'h22);

        $display("[TB] abort by deselect");
        base_q = rx_q.size(); base_v = valid_cnt; base_a = abort_cnt;
        set_mode(1'b1, 1'b1);
        ss_low();
        spi_byte(8'hE7, 5, mi);
        frame_end();
        checkOutput("ssab_abort", 32'(abort_cnt - base_a), 32'd1);
        checkOutput("ssab_valid", 32'(valid_cnt - base_v), 32'd0);
        checkOutput("ssab_busy", 32'(Busy), 32'd0);
        ss_low();
        spi_byte(8'h55, 8, mi);
        frame_end();
        checkOutput("ssab_next_valid", 32'(valid_cnt - base_v), 32'd1);
        checkOutput("ssab_next_rx", 32'(rx_at(base_q)), 32'h55);

        $display("[TB] abort by idle timeout");
        base_q = rx_q.size(); base_v = valid_cnt; base_a = abort_cnt;
        set_mode(1'b0, 1'b0);
        ss_low();
        spi_byte(8'hB4, 5, mi);
        wait_cycles(IDLE_TIMEOUT + 8);
        checkOutput("tmo_abort", 32'(abort_cnt - base_a), 32'd1);
        checkOutput("tmo_valid", 32'(valid_cnt - base_v), 32'd0);
        checkOutput("tmo_busy", 32'(Busy), 32'd0);
        spi_byte(8'h55, 8, mi);
        frame_end();
        checkOutput("tmo_next_valid", 32'(valid_cnt - base_v), 32'd1);
        checkOutput("tmo_next_rx", 32'(rx_at(base_q)), 32'h55);
        checkOutput("tmo_abort_total", 32'(abort_cnt - base_a), 32'd1);

        $display("[TB] reset mid-byte");
        base_q = rx_q.size(); base_v = valid_cnt; base_a = abort_cnt;
        set_mode(1'b0, 1'b0);
        ss_low();
        queue_tx(8'h5A);
        spi_byte(8'hC3, 3, mi);
        RST = 1'b1;
        wait_cycles(1);
        checkOutput("mrst_miso", 32'(MISO), 32'd0);
        checkOutput("mrst_rx_data", 32'(Rx_Data), 32'd0);
        checkOutput("mrst_rx_valid", 32'(Rx_Valid), 32'd0);
        checkOutput("mrst_rx_abort", 32'(Rx_Abort), 32'd0);
        checkOutput("mrst_underrun", 32'(Tx_Underrun), 32'd0);
        checkOutput("mrst_busy", 32'(Busy), 32'd0);
        checkOutput("mrst_tx_ready", 32'(Tx_Ready), 32'd1);
        RST = 1'b0;
        wait_cycles(H);
        spi_byte(8'h96, 8, mi);
        frame_end();
        checkOutput("mrst_abort", 32'(abort_cnt - base_a), 32'd0);
        checkOutput("mrst_next_valid", 32'(valid_cnt - base_v), 32'd1);
        checkOutput("mrst_next_rx", 32'(rx_at(base_q)), 32'h96);

        $display("[TB] randomized frames");
        for (int f = 0; f < 24; f++) begin
            logic       cpol, cpha, queued;
            logic [7:0] txb;
            logic [7:0] mo[4];
            logic [7:0] got[4];
            int         nfull, partial, loads;
            cpol    = 1'($urandom_range(0, 1));
            cpha    = 1'($urandom_range(0, 1));
            queued  = 1'($urandom_range(0, 1));
            txb     = 8'($urandom);
            nfull   = int'($urandom_range(1, 3));
            partial = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            for (int k = 0; k < 4; k++) mo[k] = 8'($urandom);
            // Byte k on MISO comes from load k; only load 0 can find the queued byte.
            loads = cpha ? (nfull + ((partial != 0) ? 1 : 0)) : (1 + nfull);

            base_q = rx_q.size(); base_v = valid_cnt; base_u = underrun_cnt; base_a = abort_cnt;
            set_mode(cpol, cpha);
            if (queued) queue_tx(txb);
            ss_low();
            for (int k = 0; k < nfull; k++) spi_byte(mo[k], 8, got[k]);
            if (partial != 0) spi_byte(mo[3], partial, mi);
            frame_end();

            checkOutput($sformatf("rnd%0d_valid_cnt", f), 32'(valid_cnt - base_v), 32'(nfull));
            for (int k = 0; k < nfull; k++) begin
                checkOutput($sformatf("rnd%0d_rx%0d", f, k), 32'(rx_at(base_q + k)), 32'(mo[k]));
                checkOutput($sformatf("rnd%0d_miso%0d", f, k), 32'(got[k]),
                            32'((k == 0 && queued) ? txb : UNDERRUN_BYTE));
            end
            checkOutput($sformatf("rnd%0d_underrun", f), 32'(underrun_cnt - base_u), 32'(loads - (queued ? 1 : 0)));
            checkOutput($sformatf("rnd%0d_abort", f), 32'(abort_cnt - base_a), 32'((partial != 0) ? 1 : 0));
            checkOutput($sformatf("rnd%0d_busy", f), 32'(Busy), 32'd0);
            checkOutput($sformatf("rnd%0d_ready", f), 32'(Tx_Ready), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
